// File: rtl/cfg_frame_loader_if.sv
// rtl/cfg_frame_loader_if.sv - UART Rx byte stream in, configuration RAM write/read bus out.
interface cfg_frame_loader_if;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic [7:0] ram_in;
  logic [7:0] ram_w_addr;
  logic       ram_write_n;
  logic       ram_read;

  modport master (
    input  rx_data, rx_valid,
    output ram_in, ram_w_addr, ram_write_n, ram_read
  );

  modport slave (
    output rx_data, rx_valid,
    input  ram_in, ram_w_addr, ram_write_n, ram_read
  );
endinterface

// File: rtl/cfg_frame_loader.sv
// rtl/cfg_frame_loader.sv - sync hunt, descending-address payload load, additive checksum, RAM enable.
module cfg_frame_loader #(
  parameter int         FRAME_LEN   = 113,
  parameter logic [7:0] SYNC_BYTE   = 8'hA5,
  parameter int         TIMEOUT_CYC = 50000,
  parameter int         CNT_W       = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  cfg_frame_loader_if.master  bus,
  output logic                frame_ok,
  output logic                frame_err,
  output logic [1:0]          err_code,
  output logic                busy
);

  typedef enum logic [1:0] {IDLE, LOAD, CHECK, COMMIT} state_t;

  localparam logic [7:0]       LAST_ADDR = 8'(FRAME_LEN - 1);
  localparam logic [6:0]       LAST_K    = 7'(FRAME_LEN - 1);
  localparam logic [CNT_W-1:0] TMO_LAST  = CNT_W'(TIMEOUT_CYC - 1);

  state_t           state_q, state_d;
  logic [6:0]       k_q, k_d;
  logic [7:0]       sum_q, sum_d;
  logic [CNT_W-1:0] tmo_q, tmo_d;
  logic             cfg_valid_q, cfg_valid_d;
  logic [7:0]       ram_in_q, ram_in_d;
  logic [7:0]       addr_q, addr_d;
  logic             write_n_q, write_n_d;
  logic             ram_read_q, ram_read_d;
  logic             ok_q, ok_d;
  logic             err_q, err_d;
  logic [1:0]       code_q, code_d;
  logic             busy_q, busy_d;

  always_comb begin
    state_d     = state_q;
    k_d         = k_q;
    sum_d       = sum_q;
    tmo_d       = tmo_q;
    cfg_valid_d = cfg_valid_q;
    ram_in_d    = ram_in_q;
    addr_d      = addr_q;
    write_n_d   = 1'b1;
    ok_d        = 1'b0;
    err_d       = 1'b0;
    code_d      = code_q;
    case (state_q)
      IDLE: begin
        if (bus.rx_valid && bus.rx_data == SYNC_BYTE) begin
          state_d     = LOAD;
          k_d         = '0;
          sum_d       = '0;
          tmo_d       = '0;
          cfg_valid_d = 1'b0;
        end
      end
      LOAD, CHECK: begin
        if (bus.rx_valid) begin
          tmo_d = '0;
          if (state_q == LOAD) begin
            ram_in_d  = bus.rx_data;
            addr_d    = LAST_ADDR - {1'b0, k_q};
            write_n_d = 1'b0;
            sum_d     = sum_q + bus.rx_data;
            k_d       = k_q + 7'd1;
            if (k_q == LAST_K) state_d = CHECK;
          end else if (bus.rx_data == sum_q) begin
            state_d = COMMIT;
          end else begin
            err_d   = 1'b1;
            code_d  = 2'b01;
            state_d = IDLE;
          end
        end else if (tmo_q == TMO_LAST) begin
          // A byte arriving on the last allowed cycle takes priority over the timeout.
          err_d   = 1'b1;
          code_d  = 2'b10;
          state_d = IDLE;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      COMMIT: begin
        ok_d        = 1'b1;
        code_d      = 2'b00;
        cfg_valid_d = 1'b1;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // Registered from next-state so read enable and busy track the state change edge.
    ram_read_d = cfg_valid_d && (state_d == IDLE);
    busy_d     = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      k_q         <= '0;
      sum_q       <= '0;
      tmo_q       <= '0;
      cfg_valid_q <= 1'b0;
      ram_in_q    <= '0;
      addr_q      <= '0;
      write_n_q   <= 1'b1;
      ram_read_q  <= 1'b0;
      ok_q        <= 1'b0;
      err_q       <= 1'b0;
      code_q      <= 2'b00;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      k_q         <= k_d;
      sum_q       <= sum_d;
      tmo_q       <= tmo_d;
      cfg_valid_q <= cfg_valid_d;
      ram_in_q    <= ram_in_d;
      addr_q      <= addr_d;
      write_n_q   <= write_n_d;
      ram_read_q  <= ram_read_d;
      ok_q        <= ok_d;
      err_q       <= err_d;
      code_q      <= code_d;
      busy_q      <= busy_d;
    end
  end

  assign bus.ram_in      = ram_in_q;
  assign bus.ram_w_addr  = addr_q;
  assign bus.ram_write_n = write_n_q;
  assign bus.ram_read    = ram_read_q;
  assign frame_ok        = ok_q;
  assign frame_err       = err_q;
  assign err_code        = code_q;
  assign busy            = busy_q;

endmodule

// File: tb/tb_cfg_frame_loader.sv
// tb/tb_cfg_frame_loader.sv - bench for cfg_frame_loader: frame-position model plus directed frames.
module tb_cfg_frame_loader;
  localparam int         FL   = 113;
  localparam int         TMO  = 64;
  localparam logic [7:0] SYNC = 8'hA5;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       frame_ok, frame_err, busy;
  logic [1:0] err_code;
  int         tests = 0;
  int         fails = 0;

  cfg_frame_loader_if bif();

  cfg_frame_loader #(.FRAME_LEN(FL), .SYNC_BYTE(SYNC), .TIMEOUT_CYC(TMO), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bif),
    .frame_ok(frame_ok), .frame_err(frame_err), .err_code(err_code), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // pos: -1 hunting, 0..FL-1 next payload index, FL awaiting checksum, FL+1 committing
  int         pos = -1;
  int         gap = 0;
  int         msum = 0;
  bit         cfgv = 0;
  logic       e_wn = 1'b1, e_ok = 1'b0, e_err = 1'b0, e_read = 1'b0, e_busy = 1'b0;
  logic [7:0] e_addr = 8'h00, e_din = 8'h00;
  logic [1:0] e_code = 2'b00;
  bit         started = 0;

  always @(posedge clk) begin
    if (!rst_n) begin
      pos = -1; gap = 0; msum = 0; cfgv = 0;
      e_wn = 1; e_addr = 0; e_din = 0; e_ok = 0; e_err = 0; e_code = 0; e_read = 0; e_busy = 0;
      started = 1;
    end else begin
      e_wn = 1; e_ok = 0; e_err = 0;
      if (pos < 0) begin
        if (bif.rx_valid && bif.rx_data == SYNC) begin
          pos = 0; msum = 0; gap = 0; cfgv = 0;
        end
      end else if (pos == FL + 1) begin
        e_ok = 1; e_code = 2'b00; cfgv = 1; pos = -1;
      end else if (bif.rx_valid) begin
        gap = 0;
        if (pos < FL) begin
          e_wn = 0; e_din = bif.rx_data; e_addr = 8'(FL - 1 - pos);
          msum = (msum + int'(bif.rx_data)) % 256;
          pos++;
        end else if (int'(bif.rx_data) == msum) begin
          pos = FL + 1;
        end else begin
          e_err = 1; e_code = 2'b01; pos = -1;
        end
      end else if (gap == TMO - 1) begin
        e_err = 1; e_code = 2'b10; pos = -1;
      end else begin
        gap++;
      end
      e_read = cfgv && (pos < 0);
      e_busy = (pos >= 0);
    end
  end

  logic [7:0] mem [0:FL-1];
  int         wcount = 0, ok_cnt = 0, err_cnt = 0;

  always @(negedge clk) begin
    if (started) begin
      chk("cycle_outputs",
          {9'b0, bif.ram_write_n, bif.ram_w_addr, bif.ram_in, bif.ram_read, frame_ok, frame_err, err_code, busy},
          {9'b0, e_wn, e_addr, e_din, e_read, e_ok, e_err, e_code, e_busy});
      if (bif.ram_write_n == 1'b0) begin
        if (bif.ram_w_addr < FL) mem[bif.ram_w_addr] = bif.ram_in;
        wcount++;
      end
      if (frame_ok) ok_cnt++;
      if (frame_err) err_cnt++;
    end
  end

  task automatic clear_counts();
    wcount = 0; ok_cnt = 0; err_cnt = 0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] d);
    bif.rx_valid = 1'b1;
    bif.rx_data  = d;
    @(negedge clk);
    bif.rx_valid = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] csum, input int patch_idx, input logic [7:0] patch_val,
                            input int gap_after, input int gap_len);
    send_byte(SYNC);
    for (int i = 0; i < FL; i++) begin
      send_byte(i == patch_idx ? patch_val : 8'(i));
      if (i == gap_after) idle(gap_len);
    end
    send_byte(csum);
    idle(4);
  endtask

  initial begin
    bif.rx_valid = 1'b0;
    bif.rx_data  = 8'h00;
    repeat (3) @(negedge clk);
    chk("reset_write_n", {31'b0, bif.ram_write_n}, 32'd1);
    chk("reset_read", {31'b0, bif.ram_read}, 32'd0);
    chk("reset_busy", {31'b0, busy}, 32'd0);
    rst_n = 1'b1;
    idle(2);

    // Good frame: sum of 0..0x70 = 6328 = 0x18B8 -> checksum 0xB8
    clear_counts();
    send_frame(8'hB8, -1, 8'h00, -1, 0);
    chk("t1_writes", wcount, 32'd113);
    chk("t1_addr112", {24'b0, mem[112]}, 32'h00);
    chk("t1_addr0", {24'b0, mem[0]}, 32'h70);
    chk("t1_addr50", {24'b0, mem[50]}, 32'h3E);
    chk("t1_ok", ok_cnt, 32'd1);
    chk("t1_read", {31'b0, bif.ram_read}, 32'd1);
    chk("t1_code", {30'b0, err_code}, 32'd0);

    clear_counts();
    send_frame(8'hB9, -1, 8'h00, -1, 0);
    chk("t2_ok", ok_cnt, 32'd0);
    chk("t2_err", err_cnt, 32'd1);
    chk("t2_code", {30'b0, err_code}, 32'd1);
    chk("t2_read", {31'b0, bif.ram_read}, 32'd0);

    send_frame(8'hB8, -1, 8'h00, -1, 0);
    chk("t3_pre_read", {31'b0, bif.ram_read}, 32'd1);
    clear_counts();
    send_byte(SYNC);
    chk("t3_read_drop", {31'b0, bif.ram_read}, 32'd0);
    for (int i = 0; i < 50; i++) send_byte(8'(i));
    idle(TMO - 1);
    chk("t3_no_err_early", err_cnt, 32'd0);
    idle(3);
    chk("t3_err", err_cnt, 32'd1);
    chk("t3_code", {30'b0, err_code}, 32'd2);
    chk("t3_read", {31'b0, bif.ram_read}, 32'd0);
    chk("t3_writes", wcount, 32'd50);

    // Byte 10 = 0xA5 in-frame: 0xB8 - 0x0A + 0xA5 = 0x153 -> checksum 0x53
    clear_counts();
    send_byte(8'h11);
    send_byte(8'h22);
    idle(2);
    chk("t4_ignored", wcount, 32'd0);
    send_frame(8'h53, 10, SYNC, -1, 0);
    chk("t4_addr102", {24'b0, mem[102]}, 32'hA5);
    chk("t4_writes", wcount, 32'd113);
    chk("t4_ok", ok_cnt, 32'd1);
    chk("t4_code", {30'b0, err_code}, 32'd0);

    clear_counts();
    send_frame(8'hB8, -1, 8'h00, 20, TMO - 1);
    chk("t5_err", err_cnt, 32'd0);
    chk("t5_ok", ok_cnt, 32'd1);
    chk("t5_writes", wcount, 32'd113);

    clear_counts();
    send_byte(SYNC);
    for (int i = 0; i < 60; i++) send_byte(8'hC0);
    rst_n = 1'b0;
    @(negedge clk);
    chk("t6_rst_busy", {31'b0, busy}, 32'd0);
    chk("t6_rst_wn", {31'b0, bif.ram_write_n}, 32'd1);
    chk("t6_rst_addr", {24'b0, bif.ram_w_addr}, 32'd0);
    chk("t6_rst_code", {30'b0, err_code}, 32'd0);
    rst_n = 1'b1;
    idle(2);
    chk("t6_no_err", err_cnt, 32'd0);
    chk("t6_partial", {24'b0, mem[60]}, 32'hC0);
    clear_counts();
    send_frame(8'hB8, -1, 8'h00, -1, 0);
    chk("t6_ok", ok_cnt, 32'd1);
    chk("t6_read", {31'b0, bif.ram_read}, 32'd1);
    chk("t6_addr60", {24'b0, mem[60]}, 32'h34);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
